// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = host link / memory side.
interface inst_mem_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport master (
        input  in_valid, in_data, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into 32-bit words,
// writes them to instruction RAM and holds the core in reset until the image is in.
module inst_mem_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    inst_mem_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic [23:0] hdr_lo;
    logic [31:0] remaining;
    logic [31:0] word_cnt;
    logic        accept;
    logic        last_byte;
    logic        write_fire;

    always_comb begin
        accept     = bus.in_valid && bus.in_ready;
        last_byte  = accept && (byte_cnt == 2'd3);
        word_cnt   = {bus.in_data, hdr_lo};
        write_fire = bus.mem_we && bus.mem_ack;
        state_next = state;
        case (state)
            ST_HDR: begin
                if (last_byte) begin
                    if (word_cnt == '0)
                        state_next = ST_DONE;
                    else if (word_cnt > MEM_WORDS)
                        state_next = ST_ERR;
                    else
                        state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_byte)
                    state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (write_fire)
                    state_next = (remaining == 32'd1) ? ST_DONE : ST_LOAD;
            end
            ST_DONE, ST_ERR: begin
                if (start)
                    state_next = ST_HDR;
            end
            default: state_next = ST_HDR;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_HDR;
        else
            state <= state_next;
    end

    // Status outputs are registered from the next state so they change on the same edge as state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            cpu_rst       <= 1'b1;
            byte_cnt      <= '0;
            hdr_lo        <= '0;
            remaining     <= '0;
        end else begin
            bus.in_ready <= (state_next == ST_HDR) || (state_next == ST_LOAD);
            busy         <= (state_next == ST_HDR) || (state_next == ST_LOAD) ||
                            (state_next == ST_WRITE);
            done         <= (state_next == ST_DONE);
            err          <= (state_next == ST_ERR);
            cpu_rst      <= (state_next != ST_DONE);
            if (accept)
                byte_cnt <= byte_cnt + 2'd1;
            case (state)
                // Header shifts in from the top (little-endian count); payload shifts in
                // from the bottom so the first byte ends up in [31:24].
                ST_HDR: begin
                    if (accept) begin
                        hdr_lo <= {bus.in_data, hdr_lo[23:8]};
                        if (last_byte)
                            remaining <= word_cnt;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        bus.mem_wdata <= {bus.mem_wdata[23:0], bus.in_data};
                        if (last_byte)
                            bus.mem_we <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (write_fire) begin
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
                        remaining    <= remaining - 32'd1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        bus.mem_addr <= BASE_ADDR;
                        byte_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
